d_reg_pipe: RTL and testbench
=============================

# d_reg_pipe

Parametrised, elastic multi-lane register pipeline for the parallel-4 FFT datapath. Delays a LANES-wide sample vector by DEPTH register stages with per-stage valid tracking and valid/ready flow control. Bubbles collapse under backpressure, and a synchronous flush discards all in-flight data. It replaces chains of single-bit registers between butterfly and twiddle stages wherever a stage may stall.

## Interface
Parameters:
- WIDTH, 16, bits per lane sample
- LANES, 4, number of parallel lanes; lane k occupies bits [k*WIDTH +: WIDTH]
- DEPTH, 4, register stages; legal range 1..32
- CW, $clog2(DEPTH+1), width of the occupancy count (localparam)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous discard of all in-flight data
- in_valid  in  1  upstream data valid
- in_ready  out  1  pipeline accepts in_data this cycle
- in_data  in  LANES*WIDTH  input sample vector
- out_valid  out  1  last stage holds valid data
- out_ready  in  1  downstream accepts out_data this cycle
- out_data  out  LANES*WIDTH  last-stage sample vector
- count  out  CW  number of valid stages (registered)

## Operation
- Stages 0..DEPTH-1. Stage 0 is loaded from in_data; stage DEPTH-1 drives out_data and out_valid. Each stage has a valid bit v[i] and a data register.
- Advance rule: adv[DEPTH] = out_ready. For i from DEPTH-1 down to 0, adv[i] = !v[i] || adv[i+1]. A stage loads from its predecessor when adv[i] is 1.
- A stage i>0 loading takes v[i-1]; stage 0 loading takes in_valid. Data is copied along with the valid bit. Data of a stage that does not load holds its value.
- in_ready = adv[0] && !flush. This is a combinational path from out_ready through the whole chain, which is accepted.
- Accept: in_valid && in_ready. Pop: out_valid && out_ready.
- Bubble collapse: an empty stage always loads, so gaps close while the output is stalled.
- flush: at the next edge all v[i] and count go to 0, in_ready is 0 during the flush cycle, and data registers are unchanged. flush overrides accept and pop in the same cycle. A pop presented during a flush cycle still counts as a downstream transfer; downstream must tolerate this.
- count: count_next = count + accept - pop, or 0 on flush. Never exceeds DEPTH.
- Lanes carry no independent control; all lanes move together.
- Reset (asynchronous): all v[i]=0, all data registers=0, count=0. Therefore out_valid=0, out_data=0, and in_ready=1 on the first cycle after deassertion. Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.

## Timing
- Latency on an empty pipeline with out_ready=1: a sample accepted in cycle t appears with out_valid=1 in cycle t+DEPTH.
- Throughput: 1 vector per cycle when out_ready is held at 1.
- Full state (count==DEPTH) with out_ready=0: in_ready=0 and all stages hold.
- Full state with out_ready=1: accept and pop in the same cycle are allowed and count is unchanged.
- The out_data value when out_valid=0 is don't-care for checking, except after reset, where it is 0.

## Structure
- A shared package fft_pkg holds the default sample width (FFT_W=16) and the lane count (FFT_LANES=4); the parameter defaults reference these.
- Sub-module d_reg_stage provides one stage: WIDTH*LANES data register plus valid bit, with load enable, flush clear of the valid bit, and asynchronous reset. d_reg_pipe instantiates DEPTH of these through a generate loop and owns the adv chain and count.

## Test plan
- Reset: assert rst asynchronously mid-stream with 3 stages valid -> out_valid=0, count=0, and out_data=0 before the next edge; in_ready=1 after release.
- Latency with DEPTH=4 and out_ready=1: push 0x0001_0002_0003_0004 in cycle 0 -> out_valid=1 with the identical vector in cycle 4, and count returns to 0 in cycle 5.
- Backpressure and bubble collapse: push A in cycle 0 and B in cycle 2 with out_ready=0 -> A at the output in cycle 4, B in stage 2 by cycle 5, count=2, in_ready=1; push C and D -> count=4, in_ready=0.
- Full with simultaneous accept and pop: from count=4, raise out_ready with in_valid=1 for 8 cycles -> 8 vectors are out in order, count stays at 4, no loss or duplication.
- Flush priority: with count=3, assert flush together with in_valid=1 and out_ready=1 -> in_ready=0 that cycle, and count=0 and out_valid=0 next cycle.
- Random stress with DEPTH=1 and DEPTH=32 and randomised in_valid/out_ready -> output order matches a reference queue, count equals queue occupancy every cycle, never overflows.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: shared constants for the parallel-4 FFT datapath.
//   FFT_W     - default bits per lane sample
//   FFT_LANES - default number of parallel lanes
package fft_pkg;

    localparam int FFT_W     = 16;
    localparam int FFT_LANES = 4;

endpackage

// File: rtl/d_reg_pipe_if.sv
// d_reg_pipe_if: stream bundle for d_reg_pipe.
//   upstream   : in_valid, in_ready, in_data
//   downstream : out_valid, out_ready, out_data
//   control    : flush (synchronous discard), count (occupancy)
// The pipeline connects through the slave modport. The producer/consumer side
// connects through the master modport.
interface d_reg_pipe_if
    import fft_pkg::*;
#(
    parameter int WIDTH = FFT_W,
    parameter int LANES = FFT_LANES,
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH + 1);

    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*WIDTH-1:0]   in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*WIDTH-1:0]   out_data;
    logic [CW-1:0]            count;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/d_reg_pipe_stage.sv
// d_reg_stage: one pipeline stage holding a LANES*WIDTH data word and a valid bit.
//   clk, rst : clock, asynchronous active-high reset (clears valid and data)
//   flush    : clears the valid bit at the edge; data is left untouched
//   ld       : load enable; copies vin/din into the stage
//   vin, din : predecessor valid and data
//   vout, dout : stage valid and data
module d_reg_stage
    import fft_pkg::*;
#(
    parameter int WIDTH = FFT_W,
    parameter int LANES = FFT_LANES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   ld,
    input  logic                   vin,
    input  logic [LANES*WIDTH-1:0] din,
    output logic                   vout,
    output logic [LANES*WIDTH-1:0] dout
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vout <= 1'b0;
            dout <= '0;
        end else begin
            if (flush)   vout <= 1'b0;
            else if (ld) vout <= vin;
            // A flush only discards the data logically. The register itself keeps its value.
            if (ld && !flush) dout <= din;
        end
    end

endmodule

// File: rtl/d_reg_pipe.sv
// d_reg_pipe: elastic LANES-wide register pipeline, DEPTH stages deep.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of d_reg_pipe_if (in/out valid-ready streams,
//              flush, registered occupancy count)
// Each stage advances when it is empty or its successor advances. Empty
// stages therefore always load, and bubbles collapse behind a stalled output.
module d_reg_pipe
    import fft_pkg::*;
#(
    parameter int WIDTH = FFT_W,
    parameter int LANES = FFT_LANES,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    d_reg_pipe_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]                  vld;
    logic [DEPTH-1:0][LANES*WIDTH-1:0] dat;
    logic [DEPTH-1:0]                  adv;
    logic [CW-1:0]                     cnt;
    logic                              acc, pop;

    // The advance chain ripples from out_ready back to stage 0. A scalar
    // accumulator is used so that the vector does not read itself.
    always_comb begin
        logic a;
        a   = bus.out_ready;
        adv = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            a      = !vld[i] || a;
            adv[i] = a;
        end
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stg
            if (i == 0) begin : g_head
                d_reg_stage #(.WIDTH(WIDTH), .LANES(LANES)) u_stg (
                    .clk   (clk),
                    .rst   (rst),
                    .flush (bus.flush),
                    .ld    (adv[0]),
                    .vin   (bus.in_valid),
                    .din   (bus.in_data),
                    .vout  (vld[0]),
                    .dout  (dat[0])
                );
            end else begin : g_body
                d_reg_stage #(.WIDTH(WIDTH), .LANES(LANES)) u_stg (
                    .clk   (clk),
                    .rst   (rst),
                    .flush (bus.flush),
                    .ld    (adv[i]),
                    .vin   (vld[i-1]),
                    .din   (dat[i-1]),
                    .vout  (vld[i]),
                    .dout  (dat[i])
                );
            end
        end
    endgenerate

    assign bus.in_ready  = adv[0] && !bus.flush;
    assign bus.out_valid = vld[DEPTH-1];
    assign bus.out_data  = dat[DEPTH-1];
    assign bus.count     = cnt;

    assign acc = bus.in_valid && bus.in_ready;
    assign pop = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            cnt <= '0;
        else if (bus.flush) cnt <= '0;
        else                cnt <= cnt + CW'(acc) - CW'(pop);
    end

endmodule

// File: tb/tb_d_reg_pipe.sv
module tb_d_reg_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    d_reg_pipe_if #(.WIDTH(16), .LANES(4), .DEPTH(4))  b4  ();
    d_reg_pipe_if #(.WIDTH(16), .LANES(4), .DEPTH(1))  b1  ();
    d_reg_pipe_if #(.WIDTH(16), .LANES(4), .DEPTH(32)) b32 ();

    d_reg_pipe #(.WIDTH(16), .LANES(4), .DEPTH(4))  u4  (.clk(clk), .rst(rst), .bus(b4));
    d_reg_pipe #(.WIDTH(16), .LANES(4), .DEPTH(1))  u1  (.clk(clk), .rst(rst), .bus(b1));
    d_reg_pipe #(.WIDTH(16), .LANES(4), .DEPTH(32)) u32 (.clk(clk), .rst(rst), .bus(b32));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge. Checks are made at the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] va, vb, vc, vd;
    logic [63:0] ev [8];
    logic [63:0] xo [8];
    logic [63:0] q1[$], q32[$];
    logic [63:0] d;
    logic        a;

    initial begin
        va = 64'hAAAA_0001_AAAA_0002;
        vb = 64'hBBBB_0003_BBBB_0004;
        vc = 64'hCCCC_0005_CCCC_0006;
        vd = 64'hDDDD_0007_DDDD_0008;
        for (int k = 0; k < 8; k++) ev[k] = {16'hE000 + 16'(k), 16'h1111, 16'h2222, 16'(k)};
        xo[0] = va; xo[1] = vb; xo[2] = vc; xo[3] = vd;
        for (int k = 0; k < 4; k++) xo[4+k] = ev[k];

        {b4.flush, b4.in_valid, b4.out_ready, b4.in_data} = '0;
        {b1.flush, b1.in_valid, b1.out_ready, b1.in_data} = '0;
        {b32.flush, b32.in_valid, b32.out_ready, b32.in_data} = '0;

        // reset state
        #12;
        chk("rst_ovalid", b4.out_valid, 0);
        chk("rst_count",  b4.count, 0);
        chk("rst_odata",  b4.out_data, 0);
        rst = 1'b0;
        #1;
        chk("rst_iready", b4.in_ready, 1);

        // latency: accepted in cycle 0, visible in cycle 4
        cyc();
        b4.in_valid = 1'b1; b4.in_data = 64'h0001_0002_0003_0004; b4.out_ready = 1'b1;
        @(negedge clk);
        chk("lat_iready", b4.in_ready, 1);
        for (int c = 1; c < 4; c++) begin
            cyc(); b4.in_valid = 1'b0;
            @(negedge clk);
            chk("lat_early", b4.out_valid, 0);
        end
        cyc(); @(negedge clk);
        chk("lat_ovalid", b4.out_valid, 1);
        chk("lat_odata",  b4.out_data, 64'h0001_0002_0003_0004);
        cyc(); @(negedge clk);
        chk("lat_count0", b4.count, 0);
        chk("lat_ov0",    b4.out_valid, 0);

        // backpressure and bubble collapse
        cyc(); b4.out_ready = 1'b0; b4.in_valid = 1'b1; b4.in_data = va;   // cycle 0
        cyc(); b4.in_valid = 1'b0;                                         // cycle 1
        cyc(); b4.in_valid = 1'b1; b4.in_data = vb;                        // cycle 2
        cyc(); b4.in_valid = 1'b0;                                         // cycle 3
        cyc(); @(negedge clk);                                             // cycle 4
        chk("bp_a_ov", b4.out_valid, 1);
        chk("bp_a_od", b4.out_data, va);
        cyc(); b4.in_valid = 1'b1; b4.in_data = vc;                        // cycle 5
        @(negedge clk);
        chk("bp_count2", b4.count, 2);
        chk("bp_iready", b4.in_ready, 1);
        chk("bp_b_stg2", u4.dat[2], vb);
        cyc(); b4.in_data = vd;                                            // cycle 6
        cyc(); b4.in_data = ev[0];                                         // cycle 7
        @(negedge clk);
        chk("full_count", b4.count, 4);
        chk("full_irdy",  b4.in_ready, 0);
        chk("full_hold",  b4.out_data, va);

        // full, simultaneous accept and pop
        for (int k = 0; k < 8; k++) begin
            cyc(); b4.out_ready = 1'b1; b4.in_valid = 1'b1; b4.in_data = ev[k];
            @(negedge clk);
            chk("ap_ov",    b4.out_valid, 1);
            chk("ap_od",    b4.out_data, xo[k]);
            chk("ap_count", b4.count, 4);
            chk("ap_irdy",  b4.in_ready, 1);
        end

        // flush priority: drain one item, then flush with accept and pop requested
        cyc(); b4.in_valid = 1'b0;
        cyc(); b4.flush = 1'b1; b4.in_valid = 1'b1; b4.in_data = va;
        @(negedge clk);
        chk("fl_count3", b4.count, 3);
        chk("fl_irdy",   b4.in_ready, 0);
        cyc(); b4.flush = 1'b0; b4.in_valid = 1'b0;
        @(negedge clk);
        chk("fl_count0", b4.count, 0);
        chk("fl_ov0",    b4.out_valid, 0);

        // asynchronous reset with 3 stages valid
        cyc(); b4.out_ready = 1'b0; b4.in_valid = 1'b1; b4.in_data = vb;
        cyc(); b4.in_data = vc;
        cyc(); b4.in_data = vd;
        cyc(); b4.in_valid = 1'b0;
        @(negedge clk);
        chk("ar_count3", b4.count, 3);
        #2 rst = 1'b1;
        #1;
        chk("ar_ov",    b4.out_valid, 0);
        chk("ar_count", b4.count, 0);
        chk("ar_od",    b4.out_data, 0);
        @(posedge clk); #3 rst = 1'b0;
        #1;
        chk("ar_irdy", b4.in_ready, 1);

        // random stress on DEPTH=1 and DEPTH=32 against reference queues
        for (int n = 0; n < 3000; n++) begin
            cyc();
            b1.in_valid   = ($urandom_range(3) != 0);
            b1.out_ready  = ($urandom_range(1) != 0);
            b1.flush      = ($urandom_range(63) == 0);
            b1.in_data    = {$urandom, $urandom};
            b32.in_valid  = ($urandom_range(3) != 0);
            b32.out_ready = ($urandom_range(2) != 0) && (n % 400 > 150);
            b32.flush     = ($urandom_range(127) == 0);
            b32.in_data   = {$urandom, $urandom};
            @(negedge clk);

            chk("s1_count", b1.count, 64'(q1.size()));
            chk("s1_irdy", b1.in_ready, !b1.flush && (q1.size() < 1 || b1.out_ready));
            if (b1.out_valid) begin
                if (q1.size() == 0) chk("s1_spur", 1, 0);
                else                chk("s1_data", b1.out_data, q1[0]);
            end
            a = b1.in_valid && b1.in_ready; d = b1.in_data;
            if (b1.flush) q1.delete();
            else begin
                if (b1.out_valid && b1.out_ready && q1.size() > 0) void'(q1.pop_front());
                if (a) q1.push_back(d);
            end

            chk("s32_count", b32.count, 64'(q32.size()));
            chk("s32_irdy", b32.in_ready, !b32.flush && (q32.size() < 32 || b32.out_ready));
            if (b32.out_valid) begin
                if (q32.size() == 0) chk("s32_spur", 1, 0);
                else                 chk("s32_data", b32.out_data, q32[0]);
            end
            a = b32.in_valid && b32.in_ready; d = b32.in_data;
            if (b32.flush) q32.delete();
            else begin
                if (b32.out_valid && b32.out_ready && q32.size() > 0) void'(q32.pop_front());
                if (a) q32.push_back(d);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
